// File: rtl/regfile_pkg.sv
// Shared register-file constants and scheduler state type.
//   NREG     : number of architectural registers
//   ADDR_W   : register address width
//   ZERO_REG : hardwired register, never written
package regfile_pkg;

    localparam int unsigned NREG   = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NREG - 1);

    // Final address issued by the zero-fill sequence (ZERO_REG is skipped).
    localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(NREG - 2);

    typedef enum logic [0:0] {
        SCHED_CLEAR = 1'b0,
        SCHED_RUN   = 1'b1
    } sched_state_t;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Requester / decoder-side bus of the register-file write scheduler.
//   stall     : holds off all writes this cycle
//   req       : per-requester level write request
//   req_addr  : packed destination registers, slot i at [i*ADDR_W +: ADDR_W]
//   req_data  : packed write data, slot i at [i*DATA_W +: DATA_W]
//   gnt       : one-hot grant, combinational
//   wr_en     : decoder enable, registered
//   wr_addr   : decoder select, registered
//   wr_data   : register write data, registered
//   init_done : zero-fill complete, registered
// master = requesters/decoder side, slave = scheduler.
interface regfile_wr_sched_if
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 64
);

    logic                     stall;
    logic [NREQ-1:0]          req;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          gnt;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     init_done;

    modport master (
        output stall, req, req_addr, req_data,
        input  gnt, wr_en, wr_addr, wr_data, init_done
    );

    modport slave (
        input  stall, req, req_addr, req_data,
        output gnt, wr_en, wr_addr, wr_data, init_done
    );

endinterface

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// found searching upward from ptr_i, wrapping modulo NREQ.
//   req_i : request vector
//   ptr_i : highest-priority requester index
//   gnt_o : one-hot grant (zero when no request)
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Priority scan starting at ptr_i; first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % int'(NREQ));
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler. After reset it zero-fills registers
// 0..NREG-2, then shares the single write port among NREQ requesters with
// round-robin arbitration. Decoder enable/select and data are registered.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : requester / decoder bus (slave side)
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    regfile_wr_sched_if.slave  bus
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              init_done_q, init_done_d;

    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   gnt;
    logic              any_gnt;
    logic [PTR_W-1:0]  sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Requests are invisible while clearing or stalled, so stall cannot move rr_ptr.
    assign arb_req = ((state_q == SCHED_RUN) && !bus.stall) ? bus.req : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (arb_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt)
    );

    assign any_gnt = |gnt;
    assign bus.gnt = gnt;

    // One-hot mux of the granted requester's payload.
    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_idx  = PTR_W'(i);
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;

        case (state_q)
            SCHED_CLEAR: begin
                if (!bus.stall) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_cnt_q;
                    wr_data_d = '0;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == LAST_CLR) begin
                        state_d     = SCHED_RUN;
                        init_done_d = 1'b1;
                    end
                end
            end
            SCHED_RUN: begin
                if (any_gnt) begin
                    // A write to ZERO_REG is consumed but suppressed at the decoder.
                    wr_en_d   = (sel_addr != ZERO_REG);
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                    rr_ptr_d  = (sel_idx == PTR_W'(NREQ - 1)) ? '0 : sel_idx + PTR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCHED_CLEAR;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.init_done = init_done_q;

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
Write-port scheduler for the 32-entry register file, whose write enables come from the 5-to-32 decoder tree built from 3-to-8 decoders.
- After reset, sequences a zero-fill of every writable register.
- Then shares the single write port among NREQ requesters (ALU writeback, load writeback, etc.) using round-robin arbitration.
- Drives the decoder enable/select (wr_en, wr_addr) and write data with registered timing.

Parameters:
NREQ, 4, number of write requesters
NREG, 32, register count
ADDR_W, 5, register address width (log2 NREG)
DATA_W, 64, register data width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  holds off all writes this cycle (clear and run)
req  input  NREQ  per-requester write request, level, held until granted
req_addr  input  NREQ*ADDR_W  packed per-requester destination register, slot i at [i*ADDR_W +: ADDR_W]
req_data  input  NREQ*DATA_W  packed per-requester write data, slot i at [i*DATA_W +: DATA_W]
gnt  output  NREQ  one-hot grant, combinational, same cycle as accepted req
wr_en  output  1  decoder enable, registered
wr_addr  output  ADDR_W  decoder select, registered
wr_data  output  DATA_W  register write data, registered
init_done  output  1  high once zero-fill complete, registered

Behaviour:
- Reset (asynchronous, reset_n low) sets:
  - state=CLEAR, clr_cnt=0, rr_ptr=0
  - wr_en=0, wr_addr=0, wr_data=0, init_done=0
  - gnt=0 while in CLEAR
- Reset mid-operation aborts any clear or write in progress. On release the block restarts from CLEAR. Nothing is retained.
- FSM states: CLEAR and RUN only. RUN is terminal until reset.
- CLEAR, per edge with stall=0:
  - wr_en<=1, wr_addr<=clr_cnt, wr_data<=0, clr_cnt<=clr_cnt+1.
  - Covers addresses 0..NREG-2 (0..30). ZERO_REG (31) is never written.
- CLEAR, edge with stall=1: wr_en<=0; clr_cnt and state hold.
- CLEAR exit: on the edge that issues address NREG-2, state<=RUN and init_done<=1.
  - With no stalls, the writes occur on edges 1..31 and init_done is high after edge 31.
- In CLEAR, req is ignored and gnt=0.
- RUN arbitration:
  - If stall=0, gnt selects the first asserted req searching upward from rr_ptr, wrapping modulo NREQ.
  - If stall=1 or no req is asserted, gnt=0.
- RUN on grant to requester i:
  - Next edge: wr_addr<=req_addr[i], wr_data<=req_data[i], rr_ptr<=(i+1) mod NREQ.
  - wr_en<=1, unless req_addr[i]==ZERO_REG. Then wr_en<=0; the request still counts as granted and is consumed.
- RUN with no grant: wr_en<=0. wr_addr, wr_data and rr_ptr hold.
- Latency: one-cycle write latency from gnt to wr_en. Throughput is one write per cycle.
- Requester contract:
  - Keep req, addr and data stable until gnt is seen.
  - Drop or change req on the cycle after gnt.
  - The scheduler does not buffer.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Simultaneous stall and reqs: stall wins. rr_ptr is unchanged.

Decomposition:
- regfile_pkg (shared package) holds:
  - NREG, ADDR_W, ZERO_REG=31
  - typedef enum {SCHED_CLEAR, SCHED_RUN} sched_state_t
- One sub-module, rr_arbiter:
  - Parameter NREQ; inputs req and ptr; output one-hot gnt.
  - Purely combinational.
  - rr_ptr storage stays in regfile_wr_sched.

Test Plan:
1. Reset release, no stall, no req -> wr_en high on edges 1..31, wr_addr=0..30, wr_data=0, addr 31 never written; init_done rises after edge 31, then wr_en=0.
2. After init, req[2] alone with addr 7, data 0xDEAD -> gnt=4'b0100 same cycle; next edge wr_en=1, wr_addr=7, wr_data=0xDEAD; rr_ptr=3.
3. After init, req=4'b1111 held for 5 cycles with addr i+1 -> gnt sequence 0,1,2,3,0; wr_addr sequence 1,2,3,4,1.
4. req[1] with addr 31, data 0x55 -> gnt[1]=1; next edge wr_en=0; rr_ptr advances to 2.
5. stall=1 for 3 cycles during CLEAR at clr_cnt=10, then with req=4'b0011 in RUN -> CLEAR pauses and completes on edge 34 with addresses unchanged; in RUN, gnt=0 and wr_en=0 while stalled; first grant after stall goes to requester at rr_ptr.
6. reset_n pulsed low during CLEAR at clr_cnt=20 and again in RUN with wr_en=1 -> outputs zero immediately (asynchronous); after release, full 31-write clear repeats from address 0; init_done=0 until complete.
